// File: rtl/mux_sel_seq_pkg.sv
// Shared definitions for the mux select sequencer: state encoding, control-word
// field positions and the timer width helper.
package mux_sel_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_BREAK   = 3'd1,
    ST_SETUP   = 3'd2,
    ST_ON      = 3'd3,
    ST_OFFHOLD = 3'd4
  } state_t;

  localparam int unsigned EN_BIT   = 31;
  localparam int unsigned GRP_LSB  = 28;
  localparam int unsigned ADDR_LSB = 24;
  localparam int unsigned POT_LSB  = 0;
  localparam int unsigned GRP_W    = 3;
  localparam int unsigned ADDR_W   = 4;
  localparam int unsigned POT_W    = 16;

  typedef struct packed {
    logic              en;
    logic [GRP_W-1:0]  grp;
    logic [ADDR_W-1:0] addr;
    logic [POT_W-1:0]  pot;
  } ctrl_t;

  // Timer must hold the largest phase length.
  function automatic int unsigned cnt_width(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

  // A group outside the implemented range behaves as a disable.
  function automatic logic grp_valid(ctrl_t c, int unsigned ng);
    return c.en && (32'(c.grp) < ng);
  endfunction

endpackage

// File: rtl/sel_delay_cnt.sv
// Loadable down-counter shared by all timed sequencer phases; done_c is high at zero.
module sel_delay_cnt #(
  parameter int unsigned W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         hold,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done_c
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                cnt <= '0;
    else if (hold)          cnt <= '0;
    else if (load)          cnt <= load_val;
    else if (cnt != '0)     cnt <= cnt - W'(1);
  end

  assign done_c = (cnt == '0);

endmodule

// File: rtl/mux_sel_seq.sv
// Break-before-make mux group sequencer with inhibit interlock and pot SPI load request.
module mux_sel_seq
  import mux_sel_seq_pkg::*;
#(
  parameter int unsigned    NG       = 3,
  parameter int unsigned    AW       = 3,
  parameter int unsigned    T_BBM    = 25,
  parameter int unsigned    T_SET    = 4,
  parameter int unsigned    T_OFF    = 25,
  parameter logic [NG-1:0]  POT_MASK = NG'(3'b100)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sel,
  input  logic          wr_stb,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata,
  input  logic [NG-1:0] inhibit,
  output logic [AW-1:0] mux_addr,
  output logic [NG-1:0] mux_en,
  output logic          active,
  output logic          spi_req,
  input  logic          spi_ack,
  output logic [15:0]   pot_data
);

  localparam int unsigned CW        = cnt_width(T_BBM, T_SET, T_OFF);
  localparam logic [3:0]  ADDR_MASK = 4'((1 << AW) - 1);

  state_t          state, state_d;
  ctrl_t           shadow, live, live_d, wr_ctrl_c;
  logic            rst_hold, pending, pending_d, brk_on, brk_on_d;
  logic            inh_wait, inh_wait_d, spi_req_d, wr_c, inh_now_c, busy_c;
  logic            cnt_load_c, cnt_done_c;
  logic [CW-1:0]   cnt_val_c;
  logic [7:0]      inh_ext_c, pot_ext_c, en_ext_c;
  logic [NG-1:0]   mux_en_d;
  logic [AW-1:0]   mux_addr_d;
  logic            active_d;
  logic [15:0]     pot_d;
  logic            unused_c;

  assign wr_c      = sel & wr_stb;
  assign inh_ext_c = 8'(inhibit);
  assign pot_ext_c = 8'(POT_MASK);
  assign inh_now_c = inh_ext_c[live.grp];
  assign busy_c    = (state != ST_IDLE) && (state != ST_ON);
  assign unused_c  = ^{wdata[23:16], live.en, live.addr, en_ext_c};

  always_comb begin
    wr_ctrl_c.en   = wdata[EN_BIT];
    wr_ctrl_c.grp  = wdata[GRP_LSB +: GRP_W];
    wr_ctrl_c.addr = wdata[ADDR_LSB +: ADDR_W] & ADDR_MASK;
    wr_ctrl_c.pot  = wdata[POT_LSB +: POT_W];
  end

  sel_delay_cnt #(.W(CW)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .hold     (rst_hold),
    .load     (cnt_load_c),
    .load_val (cnt_val_c),
    .done_c   (cnt_done_c)
  );

  // State and registered outputs; one idle edge after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_hold <= 1'b1;
      state    <= ST_IDLE;
      shadow   <= '0;
      live     <= '0;
      pending  <= 1'b0;
      brk_on   <= 1'b0;
      inh_wait <= 1'b0;
      spi_req  <= 1'b0;
      mux_en   <= '0;
      mux_addr <= '0;
      active   <= 1'b0;
      pot_data <= '0;
      rdata    <= '0;
    end else if (rst_hold) begin
      rst_hold <= 1'b0;
    end else begin
      state    <= state_d;
      if (wr_c) shadow <= wr_ctrl_c;
      live     <= live_d;
      pending  <= pending_d;
      brk_on   <= brk_on_d;
      inh_wait <= inh_wait_d;
      spi_req  <= spi_req_d;
      mux_en   <= mux_en_d;
      mux_addr <= mux_addr_d;
      active   <= active_d;
      pot_data <= pot_d;
      rdata    <= sel ? {shadow.en, shadow.grp, shadow.addr, 3'(state), spi_req,
                         inh_wait, busy_c, 2'b00, pot_data} : 32'd0;
    end
  end

  // Next-state and timer control.
  always_comb begin
    state_d    = state;
    live_d     = live;
    pending_d  = pending | wr_c;
    brk_on_d   = brk_on;
    inh_wait_d = 1'b0;
    cnt_load_c = 1'b0;
    cnt_val_c  = '0;
    case (state)
      ST_IDLE: begin
        if (pending) begin
          state_d    = ST_BREAK;
          brk_on_d   = 1'b0;
          cnt_load_c = 1'b1;
          cnt_val_c  = CW'(T_BBM - 1);
        end
      end
      ST_BREAK: begin
        if (cnt_done_c) begin
          live_d     = shadow;
          pending_d  = wr_c;
          brk_on_d   = 1'b0;
          cnt_load_c = 1'b1;
          if (grp_valid(shadow, NG)) begin
            state_d   = ST_SETUP;
            cnt_val_c = CW'(T_SET - 1);
          end else begin
            state_d   = ST_OFFHOLD;
            cnt_val_c = CW'(T_OFF - 1);
          end
        end
      end
      ST_SETUP: begin
        if (pending) begin
          state_d    = ST_BREAK;
          brk_on_d   = 1'b0;
          cnt_load_c = 1'b1;
          cnt_val_c  = CW'(T_BBM - 1);
        end else if (cnt_done_c) begin
          if (inh_now_c) inh_wait_d = 1'b1;
          else           state_d    = ST_ON;
        end
      end
      ST_ON: begin
        if (pending) begin
          state_d    = ST_BREAK;
          brk_on_d   = 1'b1;
          cnt_load_c = 1'b1;
          cnt_val_c  = CW'(T_BBM - 1);
        end else if (inh_now_c) begin
          state_d    = ST_SETUP;
          cnt_load_c = 1'b1;
          cnt_val_c  = CW'(T_SET - 1);
        end
      end
      ST_OFFHOLD: begin
        if (pending) begin
          state_d    = ST_BREAK;
          brk_on_d   = 1'b0;
          cnt_load_c = 1'b1;
          cnt_val_c  = CW'(T_BBM - 1);
        end else if (cnt_done_c) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    spi_req_d = ((state_d == ST_ON) && (state != ST_ON) && pot_ext_c[live_d.grp])
              | (spi_req & ~spi_ack);
  end

  // Output decode from the next state so enables and address stay registered.
  always_comb begin
    mux_en_d   = '0;
    mux_addr_d = mux_addr;
    active_d   = 1'b0;
    en_ext_c   = 8'(1) << live_d.grp;
    case (state_d)
      ST_IDLE:    mux_addr_d = '0;
      ST_SETUP:   mux_addr_d = live_d.addr[AW-1:0];
      ST_ON: begin
        mux_addr_d = live_d.addr[AW-1:0];
        mux_en_d   = en_ext_c[NG-1:0];
        active_d   = 1'b1;
      end
      ST_OFFHOLD: active_d = 1'b1;
      ST_BREAK:   active_d = brk_on_d;
      default:    active_d = 1'b0;
    endcase
    pot_d = pot_ext_c[live_d.grp] ? live_d.pot : 16'd0;
  end

endmodule

// File: tb/tb_mux_sel_seq.sv
// Directed bench for mux_sel_seq with default parameters.
module tb_mux_sel_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        wr_stb = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic [2:0]  inhibit = '0;
  logic [2:0]  mux_addr;
  logic [2:0]  mux_en;
  logic        active;
  logic        spi_req;
  logic        spi_ack = 1'b0;
  logic [15:0] pot_data;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [2:0]  prev_addr = '0;

  mux_sel_seq dut (
    .clk      (clk),
    .rst      (rst),
    .sel      (sel),
    .wr_stb   (wr_stb),
    .wdata    (wdata),
    .rdata    (rdata),
    .inhibit  (inhibit),
    .mux_addr (mux_addr),
    .mux_en   (mux_en),
    .active   (active),
    .spi_req  (spi_req),
    .spi_ack  (spi_ack),
    .pot_data (pot_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance n cycles, sampling at the falling edge; enables must be off whenever the address moves.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (mux_addr !== prev_addr) check("addr_change_en_off", 32'(mux_en), 32'd0);
      prev_addr = mux_addr;
    end
  endtask

  task automatic do_write(input logic [31:0] d);
    sel = 1'b1; wr_stb = 1'b1; wdata = d;
    @(posedge clk);
    @(negedge clk);
    sel = 1'b0; wr_stb = 1'b0;
  endtask

  initial begin
    // Reset state
    tick(3);
    check("rst_mux_en", 32'(mux_en), 32'd0);
    check("rst_mux_addr", 32'(mux_addr), 32'd0);
    check("rst_active", 32'(active), 32'd0);
    check("rst_spi_req", 32'(spi_req), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    rst = 1'b0;
    tick(2);

    // Select GRP0/ADDR1 from idle
    do_write(32'h8100_0000);
    check("w1_c0_en", 32'(mux_en), 32'd0);
    tick(25);
    check("w1_c25_addr", 32'(mux_addr), 32'd0);
    tick(1);
    check("w1_c26_addr", 32'(mux_addr), 32'd1);
    check("w1_c26_en", 32'(mux_en), 32'd0);
    tick(3);
    check("w1_c29_en", 32'(mux_en), 32'd0);
    tick(1);
    check("w1_c30_en", 32'(mux_en), 32'd1);
    check("w1_c30_active", 32'(active), 32'd1);

    // Reselect GRP1/ADDR2 while on
    do_write(32'h9200_0000);
    check("w2_c0_en", 32'(mux_en), 32'd1);
    tick(1);
    check("w2_c1_en", 32'(mux_en), 32'd0);
    check("w2_c1_active", 32'(active), 32'd1);
    tick(24);
    check("w2_c25_addr", 32'(mux_addr), 32'd1);
    tick(1);
    check("w2_c26_addr", 32'(mux_addr), 32'd2);
    tick(3);
    check("w2_c29_en", 32'(mux_en), 32'd0);
    tick(1);
    check("w2_c30_en", 32'(mux_en), 32'd2);

    // Readback while on, then deselected
    sel = 1'b1;
    tick(1);
    check("rd_on", rdata, 32'h9260_0000);
    sel = 1'b0;
    tick(1);
    check("rd_nosel", rdata, 32'd0);

    // Disable from on: break then off-hold keep active for 50 cycles
    do_write(32'h0000_0000);
    check("w3_c0_active", 32'(active), 32'd1);
    tick(1);
    check("w3_c1_en", 32'(mux_en), 32'd0);
    tick(49);
    check("w3_c50_active", 32'(active), 32'd1);
    tick(1);
    check("w3_c51_active", 32'(active), 32'd0);
    check("w3_c51_addr", 32'(mux_addr), 32'd0);

    // Inhibited group waits in setup
    inhibit = 3'b001;
    do_write(32'h8000_0000);
    tick(30);
    check("inh_c30_en", 32'(mux_en), 32'd0);
    sel = 1'b1;
    tick(1);
    check("inh_rd", rdata, 32'h804C_0000);
    sel = 1'b0;
    inhibit = 3'b000;
    tick(1);
    check("inh_release_en", 32'(mux_en), 32'd1);

    // Inhibit while on drops the enable and re-arms through setup
    inhibit = 3'b001;
    tick(1);
    check("rearm_drop_en", 32'(mux_en), 32'd0);
    check("rearm_active", 32'(active), 32'd0);
    inhibit = 3'b000;
    tick(3);
    check("rearm_c4_en", 32'(mux_en), 32'd0);
    tick(1);
    check("rearm_c5_en", 32'(mux_en), 32'd1);

    // Pot group raises an SPI load request
    do_write(32'hA000_1234);
    tick(25);
    check("pot_c25_data", 32'(pot_data), 32'd0);
    tick(1);
    check("pot_c26_data", 32'(pot_data), 32'h1234);
    tick(3);
    check("pot_c29_req", 32'(spi_req), 32'd0);
    tick(1);
    check("pot_c30_en", 32'(mux_en), 32'd4);
    check("pot_c30_req", 32'(spi_req), 32'd1);
    tick(2);
    check("pot_req_hold", 32'(spi_req), 32'd1);
    spi_ack = 1'b1;
    tick(1);
    spi_ack = 1'b0;
    check("pot_ack_clear", 32'(spi_req), 32'd0);

    // Reset mid-setup clears outputs without a clock edge
    do_write(32'h8100_0000);
    tick(27);
    check("rst_mid_addr_pre", 32'(mux_addr), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_addr", 32'(mux_addr), 32'd0);
    check("rst_mid_en", 32'(mux_en), 32'd0);
    check("rst_mid_active", 32'(active), 32'd0);
    prev_addr = mux_addr;
    tick(2);
    rst = 1'b0;
    tick(40);
    check("post_rst_en", 32'(mux_en), 32'd0);
    check("post_rst_addr", 32'(mux_addr), 32'd0);
    do_write(32'h8100_0000);
    tick(30);
    check("post_rst_write_en", 32'(mux_en), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
